opendap_ap_mux: RTL



---
 rtl/opendap_pkg.sv | 21 ++
 rtl/opendap_ap_mux_if.sv | 52 +++++
 rtl/opendap_ap_sel_decode.sv | 23 ++
 rtl/opendap_ap_mux.sv | 109 ++++++++++
 4 files changed

// File: rtl/opendap_pkg.sv
// Shared constants for the opendap debug-port slice: bus widths, AP router state
// encoding and a helper that sizes an AP index for a given AP count.
package opendap_pkg;

   localparam int AP_SEL_W  = 8;
   localparam int AP_ADDR_W = 6;
   localparam int AP_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUED   = 2'd1,
      ST_BUSY     = 2'd2,
      ST_NULLRESP = 2'd3
   } ap_state_e;

   // Index width that exactly spans N APs, never narrower than one bit.
   function automatic int ap_idx_w(input int n_aps);
      return (n_aps > 1) ? $clog2(n_aps) : 1;
   endfunction

endpackage

// File: rtl/opendap_ap_mux_if.sv
// DP-side AP access port and AP-array side bus of the multi-AP router.
// The master modport is always the side that issues accesses.
interface opendap_dp_ap_if;
   import opendap_pkg::*;

   logic [AP_SEL_W-1:0]  ap_sel;
   logic [AP_ADDR_W-1:0] ap_addr;
   logic [AP_DATA_W-1:0] ap_wdata;
   logic                 ap_wen;
   logic                 ap_ren;
   logic                 ap_abort;
   logic [AP_DATA_W-1:0] ap_rdata;
   logic                 ap_rdy;
   logic                 ap_err;

   modport master (
      output ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
      input  ap_rdata, ap_rdy, ap_err
   );

   modport slave (
      input  ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
      output ap_rdata, ap_rdy, ap_err
   );

endinterface

interface opendap_apacc_if #(
   parameter int N_APS = 4
);
   import opendap_pkg::*;

   logic [AP_ADDR_W-1:0]       dpacc_addr;
   logic [AP_DATA_W-1:0]       dpacc_wdata;
   logic [N_APS-1:0]           dpacc_wen;
   logic [N_APS-1:0]           dpacc_ren;
   logic [N_APS-1:0]           dpacc_abort;
   logic [AP_DATA_W*N_APS-1:0] dpacc_rdata;
   logic [N_APS-1:0]           dpacc_rdy;
   logic [N_APS-1:0]           dpacc_err;

   modport master (
      output dpacc_addr, dpacc_wdata, dpacc_wen, dpacc_ren, dpacc_abort,
      input  dpacc_rdata, dpacc_rdy, dpacc_err
   );

   modport slave (
      input  dpacc_addr, dpacc_wdata, dpacc_wen, dpacc_ren, dpacc_abort,
      output dpacc_rdata, dpacc_rdy, dpacc_err
   );

endinterface

// File: rtl/opendap_ap_sel_decode.sv
// Combinational APSEL decode: maps an APSEL onto a populated AP index, or flags
// it as unmapped when it falls below the base or beyond the last populated AP.
module opendap_ap_sel_decode
   import opendap_pkg::*;
#(
   parameter int                  N_APS       = 4,
   parameter logic [AP_SEL_W-1:0] AP_SEL_BASE = 8'h00,
   localparam int                 IDX_W       = ap_idx_w(N_APS)
) (
   input  logic [AP_SEL_W-1:0] ap_sel_i,
   output logic                mapped_o,
   output logic [IDX_W-1:0]    idx_o
);

   localparam logic [AP_SEL_W:0] N_APS_EXT = (AP_SEL_W + 1)'(N_APS);

   logic [AP_SEL_W-1:0] idx_full;

   assign idx_full = ap_sel_i - AP_SEL_BASE;
   assign mapped_o = (ap_sel_i >= AP_SEL_BASE) && ({1'b0, idx_full} < N_APS_EXT);
   assign idx_o    = idx_full[IDX_W-1:0];

endmodule

// File: rtl/opendap_ap_mux.sv
// Multi-AP access router: decodes APSEL, strobes exactly one AP, tracks the
// outstanding transfer and answers unpopulated APSELs with RAZ/WI.
module opendap_ap_mux
   import opendap_pkg::*;
#(
   parameter int                  N_APS       = 4,
   parameter logic [AP_SEL_W-1:0] AP_SEL_BASE = 8'h00
) (
   input  logic            swclk,
   input  logic            rst_n,
   opendap_dp_ap_if.slave  dp,
   opendap_apacc_if.master ap
);

   localparam int IDX_W = ap_idx_w(N_APS);

   ap_state_e            state_q, state_d;
   logic [IDX_W-1:0]     sel_q, sel_d;
   logic [AP_DATA_W-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 mapped;
   logic [IDX_W-1:0]     dec_idx;
   logic                 issue;
   logic [AP_DATA_W-1:0] ap_rdata_arr [N_APS];

   opendap_ap_sel_decode #(
      .N_APS       (N_APS),
      .AP_SEL_BASE (AP_SEL_BASE)
   ) u_decode (
      .ap_sel_i (dp.ap_sel),
      .mapped_o (mapped),
      .idx_o    (dec_idx)
   );

   assign issue = dp.ap_wen | dp.ap_ren;

   for (genvar i = 0; i < N_APS; i++) begin : g_rdata
      assign ap_rdata_arr[i] = ap.dpacc_rdata[i*AP_DATA_W +: AP_DATA_W];
   end

   always_ff @(posedge swclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      state_d = state_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               if (mapped) begin
                  state_d = ST_ISSUED;
                  sel_d   = dec_idx;
               end else begin
                  state_d = ST_NULLRESP;
               end
            end
         end
         // The selected AP may still show rdy from its previous transfer here.
         ST_ISSUED: state_d = ST_BUSY;
         ST_BUSY: begin
            if (ap.dpacc_rdy[sel_q]) begin
               rdata_d = ap_rdata_arr[sel_q];
               err_d   = ap.dpacc_err[sel_q];
               state_d = ST_IDLE;
            end
         end
         ST_NULLRESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ap.dpacc_wen = '0;
      ap.dpacc_ren = '0;
      dp.ap_rdy    = (state_q == ST_IDLE);
      // Write wins when both issue pulses arrive together.
      if ((state_q == ST_IDLE) && issue && mapped) begin
         if (dp.ap_wen) ap.dpacc_wen[dec_idx] = 1'b1;
         else           ap.dpacc_ren[dec_idx] = 1'b1;
      end
   end

   assign ap.dpacc_addr  = dp.ap_addr;
   assign ap.dpacc_wdata = dp.ap_wdata;
   assign ap.dpacc_abort = {N_APS{dp.ap_abort}};
   assign dp.ap_rdata    = rdata_q;
   assign dp.ap_err      = err_q;

endmodule
